// File: rtl/lsu_mem_master.sv
// Load/store initiator between the RV32I datapath and a word-organised data memory.
// One request in flight; builds lanes/enables for stores, extracts and extends loads.
module lsu_mem_master #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            Funct3,
   input  logic [31:0]           addr,
   input  logic [DATA_W-1:0]     wd,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [DATA_W-1:0]     rdata,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [3:0]            mem_wr,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [2:0] LAT = 3'(RD_LATENCY);

   state_t            state, state_nx;
   logic              accept, is_load, is_store, req_err, legal_acc;
   logic [3:0]        st_mask;
   logic [DATA_W-1:0] st_data;
   logic              load_q, err_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic [2:0]        cnt_q;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] ld_ext;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^addr[31:DM_ADDRESS];

   assign is_load   = MemRead;
   assign is_store  = MemWrite && !MemRead;
   assign accept    = req_valid && req_ready;
   assign legal_acc = (is_load || is_store) && !req_err;

   // Request decode: legality, byte-lane enables and lane-replicated store data.
   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      req_err = 1'b0;
      st_mask = 4'b0000;
      st_data = wd;
      if (is_load) begin
         case (Funct3)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = addr[0];
            3'b010:         req_err = |addr[1:0];
            default:        req_err = 1'b1;
         endcase
      end else if (is_store) begin
         case (Funct3)
            3'b000: begin
               st_mask = 4'b0001 << addr[1:0];
               st_data = {4{wd[7:0]}};
            end
            3'b001: begin
               req_err = addr[0];
               st_mask = 4'b0011 << addr[1:0];
               st_data = {2{wd[15:0]}};
            end
            3'b010: begin
               req_err = |addr[1:0];
               st_mask = 4'b1111;
            end
            default: req_err = 1'b1;
         endcase
      end
   end

   always_comb begin
      ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
      ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'b0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'b0, ld_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (accept) state_nx = legal_acc ? S_ISSUE : S_RESP;
         end
         S_ISSUE: state_nx = load_q ? S_WAIT : S_RESP;
         S_WAIT:  if (cnt_q == 3'd1) state_nx = S_RESP;
         S_RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // mem_wr is a one-cycle strobe: loaded at accept, cleared on every other edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wr    <= 4'b0000;
         rdata     <= '0;
         load_q    <= 1'b0;
         err_q     <= 1'b0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
         cnt_q     <= 3'd0;
      end else begin
         mem_wr <= 4'b0000;
         if (accept) begin
            load_q <= is_load;
            err_q  <= req_err;
            f3_q   <= Funct3;
            off_q  <= addr[1:0];
            if (legal_acc) begin
               mem_addr  <= {addr[DM_ADDRESS-1:2], 2'b00};
               mem_wdata <= st_data;
               mem_wr    <= st_mask;
            end
         end
         if (state == S_ISSUE)     cnt_q <= LAT;
         else if (state == S_WAIT) cnt_q <= cnt_q - 3'd1;
         if (state == S_WAIT && cnt_q == 3'd1) rdata <= ld_ext;
      end
   end

endmodule
